// File: rtl/filter_svf_mc_if.sv
// Register-write port of the multi-channel state-variable filter.
// Master drives a per-channel byte write; slave is the filter.
interface filter_svf_mc_if #(
  parameter int CHW = 2
);
  logic           iWE;
  logic [CHW-1:0] iChan;
  logic [4:0]     iAddr;
  logic [7:0]     iData;

  modport master (output iWE, iChan, iAddr, iData);
  modport slave  (input  iWE, iChan, iAddr, iData);
endinterface

// File: rtl/filter_svf_mc.sv
// Multi-channel state-variable filter sharing one 2-cycle multiplier.
// Each sample strobe runs one 8-cycle slot per channel.
module filter_svf_mc #(
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter int CHANNELS = 3
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   clkEn,
  input  logic [CHANNELS*DW-1:0] iIn,
  filter_svf_mc_if.slave         regs,
  output logic [CHANNELS*DW-1:0] oLP,
  output logic [CHANNELS*DW-1:0] oBP,
  output logic [CHANNELS*DW-1:0] oHP,
  output logic [CHANNELS*DW-1:0] oMix,
  output logic                   oValid,
  output logic                   oBusy,
  output logic                   oOverrun
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW  = DW + 1;
  localparam int XW  = DW + 3;
  localparam logic [CW-1:0] RES_BASE =
    CW'((3 << (CW - 2)) - 1);
  localparam logic signed [XW-1:0] SAT_HI =
    XW'((1 << (DW - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CHW-1:0]       ch;
  logic [2:0]           t;

  logic signed [DW-1:0] in_q   [CHANNELS];
  logic signed [SW-1:0] low    [CHANNELS];
  logic signed [SW-1:0] band   [CHANNELS];
  logic signed [SW-1:0] high   [CHANNELS];
  logic [CW-1:0]        lag0   [CHANNELS];
  logic [CW-1:0]        lag1   [CHANNELS];
  logic [10:0]          freq_s [CHANNELS];
  logic [10:0]          freq_a [CHANNELS];
  logic [3:0]           res_s  [CHANNELS];
  logic [3:0]           res_a  [CHANNELS];
  logic [2:0]           mode_s [CHANNELS];
  logic [2:0]           mode_a [CHANNELS];

  logic signed [SW-1:0]    mul_a;
  logic [CW-1:0]           mul_b;
  logic signed [SW-1:0]    prod;
  logic signed [SW+CW-1:0] full;

  logic signed [SW-1:0] op_a;
  logic [CW-1:0]        op_b;
  logic [CW-1:0]        res_coef;
  logic [CW-1:0]        target;
  logic [10:0]          tgt;
  logic [CW:0]          sum0;
  logic [CW:0]          sum1;
  logic signed [XW-1:0] mix;

  function automatic logic signed [XW-1:0] sx(
    input logic signed [SW-1:0] v
  );
    return {{2{v[SW-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] sat(
    input logic signed [XW-1:0] v
  );
    if (v > SAT_HI) return SAT_HI[DW-1:0];
    if (v < SAT_LO) return SAT_LO[DW-1:0];
    return v[DW-1:0];
  endfunction

  always_comb begin
    tgt      = (freq_a[ch] >> 1) + (freq_a[ch] >> 3);
    target   = CW'(tgt);
    res_coef = RES_BASE - (CW'(res_a[ch]) << (CW - 5));
    op_a     = (t == 3'd4) ? high[ch] : band[ch];
    op_b     = (t == 3'd1) ? res_coef : lag1[ch];
    sum0     = {1'b0, lag0[ch]} + {1'b0, target};
    sum1     = {1'b0, lag1[ch]} + {1'b0, lag0[ch]};
    mix      = '0;
    if (mode_a[ch][0]) mix = mix + sx(low[ch]);
    if (mode_a[ch][1]) mix = mix + sx(band[ch]);
    if (mode_a[ch][2]) mix = mix + sx(high[ch]);
  end

  // signed state times unsigned coefficient, both widened to full size
  assign full = $signed({{CW{mul_a[SW-1]}}, mul_a})
              * $signed({{SW{1'b0}}, mul_b});

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mul_a <= '0;
      mul_b <= '0;
      prod  <= '0;
    end else begin
      mul_a <= op_a;
      mul_b <= op_b;
      prod  <= SW'(full >>> CW);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      ch       <= '0;
      t        <= '0;
      oLP      <= '0;
      oBP      <= '0;
      oHP      <= '0;
      oMix     <= '0;
      oValid   <= 1'b0;
      oBusy    <= 1'b0;
      oOverrun <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        in_q[c]   <= '0;
        low[c]    <= '0;
        band[c]   <= '0;
        high[c]   <= '0;
        lag0[c]   <= '0;
        lag1[c]   <= '0;
        freq_s[c] <= '0;
        freq_a[c] <= '0;
        res_s[c]  <= '0;
        res_a[c]  <= '0;
        mode_s[c] <= '0;
        mode_a[c] <= '0;
      end
    end else begin
      oValid   <= 1'b0;
      oOverrun <= clkEn && (state == RUN);

      // host writes land in shadows, picked up at the slot's t0
      if (regs.iWE && int'(regs.iChan) < CHANNELS) begin
        case (regs.iAddr)
          5'h15: freq_s[regs.iChan][2:0]  <= regs.iData[2:0];
          5'h16: freq_s[regs.iChan][10:3] <= regs.iData;
          5'h17: res_s[regs.iChan]        <= regs.iData[7:4];
          5'h18: mode_s[regs.iChan]       <= regs.iData[6:4];
          default: ;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (clkEn) begin
            state <= RUN;
            ch    <= '0;
            t     <= '0;
            oBusy <= 1'b1;
            for (int c = 0; c < CHANNELS; c++)
              in_q[c] <= iIn[c*DW +: DW];
          end
        end
        RUN: begin
          t <= t + 3'd1;
          unique case (1'b1)
            t == 3'd0: begin
              freq_a[ch] <= freq_s[ch];
              res_a[ch]  <= res_s[ch];
              mode_a[ch] <= mode_s[ch];
            end
            t == 3'd2: low[ch] <= low[ch] + prod;
            t == 3'd3:
              high[ch] <= {in_q[ch][DW-1], in_q[ch]}
                        - low[ch] - prod;
            t == 3'd6: band[ch] <= band[ch] + prod;
            t == 3'd7: begin
              oLP[int'(ch)*DW +: DW]  <= sat(sx(low[ch]));
              oBP[int'(ch)*DW +: DW]  <= sat(sx(band[ch]));
              oHP[int'(ch)*DW +: DW]  <= sat(sx(high[ch]));
              oMix[int'(ch)*DW +: DW] <= sat(mix);
              lag0[ch] <= CW'(sum0 >> 1);
              lag1[ch] <= CW'(sum1 >> 1);
              if (ch == CHW'(CHANNELS - 1)) begin
                state  <= IDLE;
                oValid <= 1'b1;
                oBusy  <= 1'b0;
              end else begin
                ch <= ch + CHW'(1);
              end
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_svf_mc.sv
// Directed bench for filter_svf_mc, 3 channels of 16-bit samples.
// Expected values are worked out by hand from the filter equations.
module tb_filter_svf_mc;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CH = 3;

  logic            clk   = 1'b0;
  logic            rstN  = 1'b0;
  logic            clkEn = 1'b0;
  logic [CH*DW-1:0] iIn  = '0;
  logic [CH*DW-1:0] oLP, oBP, oHP, oMix;
  logic            oValid, oBusy, oOverrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int nv, no, d;

  filter_svf_mc_if #(.CHW(2)) regs();

  filter_svf_mc #(
    .DW(DW), .CW(CW), .CHANNELS(CH)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .clkEn(clkEn),
    .iIn(iIn),
    .regs(regs),
    .oLP(oLP),
    .oBP(oBP),
    .oHP(oHP),
    .oMix(oMix),
    .oValid(oValid),
    .oBusy(oBusy),
    .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  function automatic int g(input logic [CH*DW-1:0] v, input int c);
    logic signed [DW-1:0] s;
    s = v[c*DW +: DW];
    return int'(s);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input int a0, input int a1, input int a2);
    iIn = {DW'(a2), DW'(a1), DW'(a0)};
  endtask

  task automatic wr(input int c, input logic [4:0] a, input logic [7:0] dt);
    @(negedge clk);
    regs.iWE   = 1'b1;
    regs.iChan = 2'(c);
    regs.iAddr = a;
    regs.iData = dt;
    @(negedge clk);
    regs.iWE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN  = 1'b0;
    clkEn = 1'b0;
    regs.iWE = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // cyc counts the strobe cycle as 1
  task automatic start_pass();
    @(negedge clk);
    clkEn = 1'b1;
    @(posedge clk);
    #1;
    clkEn = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid();
    while (!oValid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!oValid) check("valid_timeout", cyc, 25);
  endtask

  task automatic run_pass();
    start_pass();
    wait_valid();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    regs.iWE   = 1'b0;
    regs.iChan = '0;
    regs.iAddr = '0;
    regs.iData = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", oValid, 0);
    check("rst_busy", oBusy, 0);
    check("rst_ovr", oOverrun, 0);
    check("rst_hp0", g(oHP, 0), 0);
    rstN = 1'b1;

    // zero coefficients: high follows the input, the rest stay 0
    set_in(1000, -500, -32768);
    wr(3, 5'h18, 8'h70);
    start_pass();
    check("busy_rise", oBusy, 1);
    wait_valid();
    check("pass_len", cyc, 25);
    check("busy_fall", oBusy, 0);
    check("hp0", g(oHP, 0), 1000);
    check("hp1", g(oHP, 1), -500);
    check("hp2", g(oHP, 2), -32768);
    check("lp0", g(oLP, 0), 0);
    check("bp0", g(oBP, 0), 0);
    check("mix0", g(oMix, 0), 0);
    check("mix2", g(oMix, 2), 0);
    @(posedge clk);
    #1;
    check("valid_pulse", oValid, 0);

    // second strobe while busy is dropped
    do_reset();
    set_in(1000, -500, -32768);
    nv = 0;
    no = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      clkEn = (i == 0 || i == 5);
      if (i == 2) set_in(7, 7, 7);
      @(posedge clk);
      #1;
      nv += int'(oValid);
      no += int'(oOverrun);
    end
    clkEn = 1'b0;
    check("ovr_pulses", no, 1);
    check("ovr_valids", nv, 1);
    check("ovr_hp0", g(oHP, 0), 1000);
    check("ovr_hp1", g(oHP, 1), -500);

    // reset at RUN(1,3)
    set_in(1000, -500, -32768);
    start_pass();
    repeat (11) @(posedge clk);
    #1;
    check("mid_busy", oBusy, 1);
    rstN = 1'b0;
    #1;
    check("mid_rst_hp0", g(oHP, 0), 0);
    check("mid_rst_busy", oBusy, 0);
    check("mid_rst_valid", oValid, 0);
    @(negedge clk);
    rstN = 1'b1;
    run_pass();
    check("mid_pass_len", cyc, 25);
    check("mid_hp0", g(oHP, 0), 1000);

    // freq written inside ch0's own slot is deferred one pass
    do_reset();
    set_in(32767, 0, 0);
    wr(0, 5'h18, 8'h20);
    start_pass();
    repeat (4) @(posedge clk);
    #1;
    wr(0, 5'h15, 8'h07);
    wr(0, 5'h16, 8'hFF);
    wait_valid();
    check("wt_hp_p1", g(oHP, 0), 32767);
    run_pass();
    run_pass();
    check("wt_bp_p3", g(oBP, 0), 0);
    run_pass();
    check("wt_bp_p4", g(oBP, 0), 159);
    check("wt_hp_p4", g(oHP, 0), 32767);
    run_pass();
    check("wt_lp_p5", g(oLP, 0), 1);
    check("wt_bp_p5", g(oBP, 0), 476);
    check("wt_hp_p5", g(oHP, 0), 32647);

    // mode mixing and output clamp
    do_reset();
    set_in(0, 0, 20000);
    wr(2, 5'h18, 8'h50);
    run_pass();
    check("mix_lphp", g(oMix, 2), 20000);
    check("mix_hp2", g(oHP, 2), 20000);
    check("mix_lp2", g(oLP, 2), 0);
    wr(2, 5'h18, 8'h60);
    wr(2, 5'h17, 8'hF0);
    wr(2, 5'h15, 8'h07);
    wr(2, 5'h16, 8'hFF);
    set_in(0, 0, 32767);
    repeat (3) run_pass();
    check("mix_clamp", g(oMix, 2), 32767);
    check("mix_bp2", g(oBP, 2), 159);
    check("mix_hp2b", g(oHP, 2), 32767);
    check("mix_ch0", g(oMix, 0), 0);

    // only ch1 gets a cutoff; DC settles through its lowpass
    do_reset();
    set_in(8000, 8000, 8000);
    wr(1, 5'h15, 8'h07);
    wr(1, 5'h16, 8'hFF);
    wr(1, 5'h18, 8'h10);
    repeat (1000) run_pass();
    d = g(oLP, 1) - 8000;
    if (d < 0) d = -d;
    check("iso_lp1_near", int'(d <= 160), 1);
    check("iso_lp0", g(oLP, 0), 0);
    check("iso_lp2", g(oLP, 2), 0);
    check("iso_hp0", g(oHP, 0), 8000);
    check("iso_hp2", g(oHP, 2), 8000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
